mem_arbiter: RTL

Shares the single-ported unified RAM between the instruction-fetch path and the data-access path of the pipelined MIPS core. The data path has priority, and an anti-starvation counter forces an instruction grant after a run of data grants. The block latches the winning request, holds it stable on the RAM port until the RAM accepts it, then returns load data and a one-cycle completion (wait low) to the winner. It sits between the caches/datapath memory interface and the RAM model.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/arb_starve_counter.sv | 46 ++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types for the pipelined MIPS core memory subsystem.
//               Provides the machine word type, the RAM arbiter state encoding
//               and the default anti-starvation threshold.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Data completions tolerated while an instruction fetch waits.
  localparam int c_starve_max_default = 4;

endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_counter
// Description : 4-bit saturating counter of data completions that occurred
//               while an instruction fetch was pending.
// Ports       : clk    - clock
//               rst    - synchronous active-high reset
//               i_inc  - count one event (ignored once saturated)
//               i_clr  - clear to zero (wins over i_inc)
//               o_cnt  - current count
//               o_sat  - count has reached MAX
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [3:0] o_cnt,
  output logic       o_sat
);

  localparam logic [3:0] c_max = 4'(MAX);

  logic [3:0] r_cnt;
  logic       w_sat;

  assign w_sat = (r_cnt == c_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = w_sat;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates the single-ported unified RAM between instruction
//               fetch and data access. Data has priority; after STARVE_MAX
//               data completions with a fetch pending, the fetch is forced.
//               The winning request is latched and held on the RAM port until
//               ram_ready; completion is a one-cycle wait=0 to the winner.
// Ports       : CLK, RST                      - clock, sync active-high reset
//               iREN, iaddr / iload, iwait    - instruction requester
//               dREN, dWEN, daddr, dstore /
//               dload, dwait                  - data requester
//               ram_REN, ram_WEN, ram_addr,
//               ram_store / ram_load,
//               ram_ready                     - RAM port
//               busy                          - arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = c_starve_max_default,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [31:0]       iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dstore,
  output logic [31:0]       dload,
  output logic              dwait,
  output logic              ram_REN,
  output logic              ram_WEN,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_store,
  input  logic [31:0]       ram_load,
  input  logic              ram_ready,
  output logic              busy
);

  arb_state_t        r_state;
  logic              r_ram_ren;
  logic              r_ram_wen;
  logic [ADDR_W-1:0] r_ram_addr;
  word_t             r_ram_store;

  logic       w_dpend;
  logic       w_sat;
  logic       w_go_i;
  logic       w_done_i;
  logic       w_done_d;
  logic       w_starve_inc;
  logic       w_starve_clr;
  logic [3:0] w_starve_cnt;

  assign w_dpend = dREN | dWEN;
  // Instruction wins in IDLE when forced by starvation or when data is quiet.
  assign w_go_i  = iREN & (w_sat | ~w_dpend);

  // A reset cycle abandons the access, so it never signals completion.
  assign w_done_i = (r_state == IGRANT) & ram_ready & ~RST;
  assign w_done_d = (r_state == DGRANT) & ram_ready & ~RST;

  assign w_starve_inc = (r_state == DGRANT) & ram_ready & iREN;
  assign w_starve_clr = (r_state == IDLE) & (~iREN | w_go_i);

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (CLK),
    .rst   (RST),
    .i_inc (w_starve_inc),
    .i_clr (w_starve_clr),
    .o_cnt (w_starve_cnt),
    .o_sat (w_sat)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_ram_ren   <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_store <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go_i) begin
            r_state     <= IGRANT;
            r_ram_ren   <= 1'b1;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= iaddr;
            r_ram_store <= '0;
          end else if (w_dpend) begin
            // A simultaneous read and write request is treated as a write.
            r_state     <= DGRANT;
            r_ram_ren   <= ~dWEN;
            r_ram_wen   <= dWEN;
            r_ram_addr  <= daddr;
            r_ram_store <= dstore;
          end
        end
        IGRANT: begin
          // Dropping iREN before the RAM answers aborts a redirected fetch.
          if (ram_ready || !iREN) begin
            r_state     <= IDLE;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_store <= '0;
          end
        end
        DGRANT: begin
          if (ram_ready) begin
            r_state     <= IDLE;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_store <= '0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_ram_ren   <= 1'b0;
          r_ram_wen   <= 1'b0;
          r_ram_addr  <= '0;
          r_ram_store <= '0;
        end
      endcase
    end
  end

  assign ram_REN   = r_ram_ren;
  assign ram_WEN   = r_ram_wen;
  assign ram_addr  = r_ram_addr;
  assign ram_store = r_ram_store;
  assign busy      = (r_state != IDLE);

  assign iwait = ~w_done_i;
  assign dwait = ~w_done_d;
  assign iload = w_done_i ? ram_load : 32'd0;
  assign dload = (w_done_d && r_ram_ren) ? ram_load : 32'd0;

  // The count itself is only consumed through o_sat.
  logic w_unused;
  assign w_unused = ^w_starve_cnt;

endmodule
`default_nettype wire
